// File: rtl/loop_regs_pkg.sv
// Shared definitions for the loop register block: fixed offsets, ID value and the
// address decoder also used by loop_lite_slave.
package loop_regs_pkg;

    localparam logic [15:0] LOOP_ID_ADDR   = 16'h0000;
    localparam logic [15:0] LOOP_SNAP_ADDR = 16'h0004;
    localparam logic [31:0] LOOP_ID_VAL    = 32'h100B_0001;

    typedef struct packed {
        logic       hit_id;
        logic       hit_snap;
        logic       hit_rw;
        logic       hit_ro;
        logic [4:0] idx;
    } addr_decode_t;

    function automatic addr_decode_t decode(
        input logic [15:0] addr,
        input logic [15:0] rw_base,
        input logic [15:0] ro_base,
        input int unsigned num_rw,
        input int unsigned num_ro
    );
        addr_decode_t d;
        logic [15:0]  rw_off;
        logic [15:0]  ro_off;
        d      = '0;
        rw_off = addr - rw_base;
        ro_off = addr - ro_base;
        // Register windows only match word-aligned addresses; anything else reads as unmapped.
        if (addr == LOOP_ID_ADDR) begin
            d.hit_id = 1'b1;
        end else if (addr == LOOP_SNAP_ADDR) begin
            d.hit_snap = 1'b1;
        end else if (addr >= rw_base && 32'(rw_off) < 4 * num_rw && addr[1:0] == 2'b00) begin
            d.hit_rw = 1'b1;
            d.idx    = rw_off[6:2];
        end else if (addr >= ro_base && 32'(ro_off) < 4 * num_ro && addr[1:0] == 2'b00) begin
            d.hit_ro = 1'b1;
            d.idx    = ro_off[6:2];
        end
        return d;
    endfunction

endpackage

// File: rtl/loop_reg_bank_rst_stretch.sv
// Retriggerable pulse stretcher: output stays high for RST_CYCLES clocks after the
// last trigger or after reset deasserts.
module loop_rst_stretch #(
    parameter int unsigned RST_CYCLES = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic trig,
    output logic rst_out
);

    localparam logic [15:0] LOAD = 16'(RST_CYCLES);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (rst || trig) begin
            cnt <= LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 16'd1;
        end
    end

    assign rst_out = (cnt != '0);

endmodule

// File: rtl/loop_reg_bank.sv
// Loop plugin control/status register bank (BAR2 box250 +0x1000), single 250MHz domain.
// Define LOOP_REGS_SNAPSHOT_EN to make RO reads return a snapshot captured by SNAP writes.
module loop_reg_bank
    import loop_regs_pkg::*;
#(
    parameter int unsigned           REG_ADDR_W  = 12,
    parameter logic [15:0]           REG_PREFIX  = 16'h0,
    parameter int unsigned           NUM_RW_REGS = 4,
    parameter int unsigned           NUM_RO_REGS = 4,
    parameter logic [REG_ADDR_W-1:0] RW_BASE     = 12'h100,
    parameter logic [REG_ADDR_W-1:0] RO_BASE     = 12'h200,
    parameter logic [31:0]           RW_RST_VAL  = 32'h0,
    parameter int unsigned           RST_CYCLES  = 16
) (
    input  logic                      reg_clk,
    input  logic                      reg_rst,
    input  logic                      reg_en,
    input  logic                      reg_we,
    input  logic [REG_ADDR_W-1:0]     reg_addr,
    input  logic [31:0]               reg_din,
    output logic [31:0]               reg_dout,
    output logic                      reg_dout_vld,
    output logic [32*NUM_RW_REGS-1:0] ctrl_q,
    output logic [NUM_RW_REGS-1:0]    ctrl_wr_pulse,
    input  logic [32*NUM_RO_REGS-1:0] stat_d,
    output logic                      user_rst
);

    logic [15:0]      addr16;
    addr_decode_t     dec;
    logic             wr;
    logic             rd;
    logic [NUM_RW_REGS-1:0] wr_sel;
    logic [31:0]      ctrl_r  [NUM_RW_REGS];
    logic [31:0]      ro_word [NUM_RO_REGS];
    logic [31:0]      rd_data;

    assign addr16 = 16'(reg_addr);
    assign dec    = decode(addr16, 16'(RW_BASE), 16'(RO_BASE), NUM_RW_REGS, NUM_RO_REGS);
    assign wr     = reg_en & reg_we;
    assign rd     = reg_en & ~reg_we;

    always_comb begin
        wr_sel = '0;
        for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
            wr_sel[i] = wr && dec.hit_rw && (32'(dec.idx) == i);
        end
    end

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            ctrl_wr_pulse <= '0;
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                ctrl_r[i] <= RW_RST_VAL;
            end
        end else begin
            ctrl_wr_pulse <= wr_sel;
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                if (wr_sel[i]) begin
                    ctrl_r[i] <= reg_din;
                end
            end
        end
    end

    always_comb begin
        ctrl_q = '0;
        for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
            ctrl_q[32*i +: 32] = ctrl_r[i];
        end
    end

`ifdef LOOP_REGS_SNAPSHOT_EN
    logic [15:0] snap_cnt;
    logic [31:0] snap_r [NUM_RO_REGS];

    // All RO words are captured on the same edge so software sees a coherent set.
    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            snap_cnt <= '0;
            for (int unsigned i = 0; i < NUM_RO_REGS; i++) begin
                snap_r[i] <= '0;
            end
        end else if (wr && dec.hit_snap) begin
            snap_cnt <= snap_cnt + 16'd1;
            for (int unsigned i = 0; i < NUM_RO_REGS; i++) begin
                snap_r[i] <= stat_d[32*i +: 32];
            end
        end
    end
`endif

    always_comb begin
        for (int unsigned i = 0; i < NUM_RO_REGS; i++) begin
`ifdef LOOP_REGS_SNAPSHOT_EN
            ro_word[i] = snap_r[i];
`else
            ro_word[i] = stat_d[32*i +: 32];
`endif
        end
    end

    always_comb begin
        rd_data = {REG_PREFIX, addr16};
        if (dec.hit_id) begin
            rd_data = LOOP_ID_VAL;
        end else if (dec.hit_snap) begin
`ifdef LOOP_REGS_SNAPSHOT_EN
            rd_data = {16'h0, snap_cnt};
`else
            rd_data = '0;
`endif
        end else if (dec.hit_rw) begin
            for (int unsigned i = 0; i < NUM_RW_REGS; i++) begin
                if (32'(dec.idx) == i) rd_data = ctrl_r[i];
            end
        end else if (dec.hit_ro) begin
            for (int unsigned i = 0; i < NUM_RO_REGS; i++) begin
                if (32'(dec.idx) == i) rd_data = ro_word[i];
            end
        end
    end

    always_ff @(posedge reg_clk) begin
        if (reg_rst) begin
            reg_dout     <= '0;
            reg_dout_vld <= 1'b0;
        end else begin
            reg_dout_vld <= rd;
            if (rd) begin
                reg_dout <= rd_data;
            end
        end
    end

    loop_rst_stretch #(
        .RST_CYCLES(RST_CYCLES)
    ) u_rst_stretch (
        .clk     (reg_clk),
        .rst     (reg_rst),
        .trig    (wr && dec.hit_id && reg_din[0]),
        .rst_out (user_rst)
    );

endmodule

// File: tb/tb_loop_reg_bank.sv
// Scoreboard bench for loop_reg_bank: reads push expected data, a negedge monitor
// pops and compares whenever reg_dout_vld is seen.
module tb_loop_reg_bank;

    localparam int NRW = 4;
    localparam int NRO = 4;

    logic          reg_clk = 1'b0;
    logic          reg_rst = 1'b1;
    logic          reg_en  = 1'b0;
    logic          reg_we  = 1'b0;
    logic [11:0]   reg_addr = '0;
    logic [31:0]   reg_din  = '0;
    logic [31:0]   reg_dout;
    logic          reg_dout_vld;
    logic [127:0]  ctrl_q;
    logic [3:0]    ctrl_wr_pulse;
    logic [127:0]  stat_d;
    logic          user_rst;

    logic [31:0]   stat_mem [NRO];
    logic [31:0]   m_rw     [NRW];
    logic [31:0]   m_snap   [NRO];
    int unsigned   m_snap_cnt;
    logic [31:0]   exp_q [$];
    int            total = 0;
    int            bad   = 0;

    always #5 reg_clk = ~reg_clk;

    always_comb begin
        stat_d = '0;
        for (int i = 0; i < NRO; i++) stat_d[32*i +: 32] = stat_mem[i];
    end

    loop_reg_bank #(
        .REG_PREFIX(16'h00AB)
    ) u_dut (
        .reg_clk       (reg_clk),
        .reg_rst       (reg_rst),
        .reg_en        (reg_en),
        .reg_we        (reg_we),
        .reg_addr      (reg_addr),
        .reg_din       (reg_din),
        .reg_dout      (reg_dout),
        .reg_dout_vld  (reg_dout_vld),
        .ctrl_q        (ctrl_q),
        .ctrl_wr_pulse (ctrl_wr_pulse),
        .stat_d        (stat_d),
        .user_rst      (user_rst)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge reg_clk);
        #1;
    endtask

    function automatic logic [127:0] model_ctrl();
        logic [127:0] v;
        for (int i = 0; i < NRW; i++) v[32*i +: 32] = m_rw[i];
        return v;
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < NRW; i++) m_rw[i] = 32'h0;
        for (int i = 0; i < NRO; i++) m_snap[i] = 32'h0;
        m_snap_cnt = 0;
    endfunction

    function automatic bit in_win(input int unsigned a, input int unsigned base, input int n);
        return a >= base && a < base + 4 * n && a % 4 == 0;
    endfunction

    function automatic logic [31:0] model_read(input logic [11:0] addr);
        int unsigned a = addr;
        if (a == 0) return 32'h100B_0001;
`ifdef LOOP_REGS_SNAPSHOT_EN
        if (a == 4) return 32'(m_snap_cnt % 65536);
        if (in_win(a, 'h200, NRO)) return m_snap[(a - 'h200) / 4];
`else
        if (a == 4) return 32'h0;
        if (in_win(a, 'h200, NRO)) return stat_mem[(a - 'h200) / 4];
`endif
        if (in_win(a, 'h100, NRW)) return m_rw[(a - 'h100) / 4];
        return 32'h00AB_0000 + a;
    endfunction

    task automatic do_write(input logic [11:0] addr, input logic [31:0] data);
        int unsigned a = addr;
        logic [3:0]  exp_pulse = '0;
        if (a != 0 && a != 4 && in_win(a, 'h100, NRW)) begin
            m_rw[(a - 'h100) / 4] = data;
            exp_pulse[(a - 'h100) / 4] = 1'b1;
        end
`ifdef LOOP_REGS_SNAPSHOT_EN
        if (a == 4) begin
            for (int i = 0; i < NRO; i++) m_snap[i] = stat_mem[i];
            m_snap_cnt++;
        end
`endif
        reg_en = 1'b1; reg_we = 1'b1; reg_addr = addr; reg_din = data;
        tick();
        reg_en = 1'b0; reg_we = 1'b0;
        chk("wr_pulse", 128'(ctrl_wr_pulse), 128'(exp_pulse));
        chk("ctrl_q", ctrl_q, model_ctrl());
    endtask

    task automatic do_read(input logic [11:0] addr);
        exp_q.push_back(model_read(addr));
        reg_en = 1'b1; reg_we = 1'b0; reg_addr = addr;
        tick();
        reg_en = 1'b0;
    endtask

    function automatic logic [11:0] pick_addr();
        case ($urandom_range(0, 4))
            0: return 12'(12'h100 + 4 * $urandom_range(0, NRW - 1));
            1: return 12'(12'h200 + 4 * $urandom_range(0, NRO - 1));
            2: return 12'h004;
            3: return 12'h000;
            default: return 12'($urandom_range(0, 4095));
        endcase
    endfunction

    always @(negedge reg_clk) begin : monitor
        logic [31:0] e;
        if (reg_dout_vld) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rd_unexpected actual_vld=1 dout=%0h required_vld=0", reg_dout);
            end else begin
                e = exp_q.pop_front();
                chk("rd_data", 128'(reg_dout), 128'(e));
            end
        end
    end

    initial begin
        int n;
        for (int i = 0; i < NRO; i++) stat_mem[i] = 32'h0;
        model_reset();

        repeat (3) tick();
        chk("rst_dout", 128'(reg_dout), 128'h0);
        chk("rst_vld", 128'(reg_dout_vld), 128'h0);
        chk("rst_ctrl_q", ctrl_q, 128'h0);
        chk("rst_pulse", 128'(ctrl_wr_pulse), 128'h0);
        chk("rst_user_rst", 128'(user_rst), 128'h1);
        reg_rst = 1'b0;

        n = 0;
        while (user_rst && n < 100) begin n++; tick(); end
        chk("user_rst_len_after_reset", 128'(n), 128'd16);

        do_read(12'h000);
        chk("rd_vld_latency", 128'(reg_dout_vld), 128'h1);
        tick();
        chk("rd_vld_drop", 128'(reg_dout_vld), 128'h0);
        chk("rd_dout_hold", 128'(reg_dout), 128'h100B_0001);

        do_write(12'h104, 32'hDEAD_BEEF);
        chk("ctrl_q_reg1", 128'(ctrl_q[63:32]), 128'hDEAD_BEEF);
        do_read(12'h104);
        chk("wr_pulse_one_cycle", 128'(ctrl_wr_pulse), 128'h0);
        tick();

        do_write(12'h000, 32'h1);
        n = 0;
        repeat (4) begin if (user_rst) n++; tick(); end
        if (user_rst) n++;
        do_write(12'h000, 32'h1);
        while (user_rst && n < 200) begin n++; tick(); end
        chk("user_rst_retrigger_len", 128'(n), 128'd21);
        do_write(12'h000, 32'h0);
        tick();
        chk("user_rst_din0_zero", 128'(user_rst), 128'h0);

        stat_mem[2] = 32'h1234;
        do_read(12'h208);
        do_write(12'h004, 32'h0);
        stat_mem[2] = 32'h5555;
        do_read(12'h208);
        do_read(12'h004);

        do_read(12'h3FC);
        do_write(12'h200, 32'hFFFF_FFFF);
        do_read(12'h200);
        tick();

        for (int k = 0; k < 300; k++) begin
            case ($urandom_range(0, 3))
                0: do_write(pick_addr(), $urandom);
                1: do_read(pick_addr());
                2: begin stat_mem[$urandom_range(0, NRO - 1)] = $urandom; tick(); end
                default: tick();
            endcase
        end
        repeat (2) tick();

        do_write(12'h108, 32'h5A5A_0001);
        reg_en = 1'b1; reg_we = 1'b0; reg_addr = 12'h108; reg_rst = 1'b1;
        tick();
        reg_en = 1'b0;
        model_reset();
        chk("rst_mid_vld", 128'(reg_dout_vld), 128'h0);
        chk("rst_mid_ctrl_q", ctrl_q, 128'h0);
        chk("rst_mid_user_rst", 128'(user_rst), 128'h1);
        tick();
        reg_rst = 1'b0;
        tick();
        do_read(12'h108);
        do_read(12'h004);
        repeat (3) tick();

        chk("scoreboard_drained", 128'(exp_q.size()), 128'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
